// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: computes the actual outcome and target, redirects fetch
// on a misprediction, queues BTB updates and keeps control/mispredict performance counters.
module branch_resolve_unit #(
    parameter int XLEN       = 32,
    parameter int BTBQ_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  op1,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic             lt_flag,
    input  logic             ltu_flag,
    input  logic             zero_flag,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             stall_req,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             btb_upd_valid,
    input  logic             btb_upd_ready,
    output logic [XLEN-1:0]  btb_upd_pc,
    output logic [XLEN-1:0]  btb_upd_target,
    output logic             btb_upd_taken,
    input  logic             perf_clr,
    output logic [CNT_W-1:0] perf_ctrl_cnt,
    output logic [CNT_W-1:0] perf_mispred_cnt
);
    localparam int PTR_W = (BTBQ_DEPTH > 1) ? $clog2(BTBQ_DEPTH) : 1;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(BTBQ_DEPTH);
    localparam logic [PTR_W:0]   EMPTY_C   = {(PTR_W + 1){1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]  FOUR_C    = {{(XLEN - 3){1'b0}}, 3'b100};

    logic            is_jal_s, is_jalr_s, is_branch_s, is_ctrl_s;
    logic            br_cond_s, actual_taken_s, mispred_s;
    logic [XLEN-1:0] sum_s, target_s, fallthrough_s;
    logic            squash_s, full_s, accept_s, enq_s, deq_s;

    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic [XLEN-1:0] q_pc_r  [BTBQ_DEPTH];
    logic [XLEN-1:0] q_tgt_r [BTBQ_DEPTH];
    logic            q_tk_r  [BTBQ_DEPTH];
    logic [PTR_W-1:0] rd_ptr_r, wr_ptr_r;
    logic [PTR_W:0]   count_r;
    logic [CNT_W-1:0] ctrl_cnt_r, mispred_cnt_r;

    // Decode the instruction and resolve outcome, target and misprediction.
    always_comb begin
        is_jal_s    = (opcode == OP_JAL);
        is_jalr_s   = (opcode == OP_JALR);
        is_branch_s = (opcode == OP_BRANCH);
        is_ctrl_s   = is_jal_s | is_jalr_s | is_branch_s;
        case (func3)
            3'b000:  br_cond_s = zero_flag;
            3'b001:  br_cond_s = ~zero_flag;
            3'b100:  br_cond_s = lt_flag;
            3'b101:  br_cond_s = ~lt_flag;
            3'b110:  br_cond_s = ltu_flag;
            3'b111:  br_cond_s = ~ltu_flag;
            default: br_cond_s = 1'b0;
        endcase
        if (is_jalr_s) begin
            sum_s    = op1 + imm;
            target_s = {sum_s[XLEN-1:1], 1'b0};
        end else begin
            sum_s    = pc + imm;
            target_s = sum_s;
        end
        fallthrough_s  = pc + FOUR_C;
        actual_taken_s = is_jal_s | is_jalr_s | (is_branch_s & br_cond_s);
        // A non-control instruction resolves not-taken, so a taken prediction mispredicts.
        mispred_s = (actual_taken_s != pred_taken) |
                    (actual_taken_s & pred_taken & (pred_target != target_s));
    end

    assign squash_s  = redirect_valid_r;
    assign full_s    = (count_r == DEPTH_C);
    assign stall_req = ex_valid & is_ctrl_s & full_s & ~squash_s;
    assign accept_s  = ex_valid & ~squash_s & ~stall_req;
    assign enq_s     = accept_s & is_ctrl_s;
    assign deq_s     = (count_r != EMPTY_C) & btb_upd_ready;

    // One-cycle fetch redirect after an accepted mispredict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= {XLEN{1'b0}};
        end else begin
            redirect_valid_r <= accept_s & mispred_s;
            if (accept_s & mispred_s) begin
                redirect_pc_r <= actual_taken_s ? target_s : fallthrough_s;
            end
        end
    end

    // BTB update FIFO: storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BTBQ_DEPTH; i++) begin
                q_pc_r[i]  <= {XLEN{1'b0}};
                q_tgt_r[i] <= {XLEN{1'b0}};
                q_tk_r[i]  <= 1'b0;
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= EMPTY_C;
        end else begin
            if (enq_s) begin
                q_pc_r[wr_ptr_r]  <= pc;
                q_tgt_r[wr_ptr_r] <= target_s;
                q_tk_r[wr_ptr_r]  <= actual_taken_s;
                wr_ptr_r          <= wr_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W - 1){1'b0}}, 1'b1};
            end
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{PTR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating performance counters; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_cnt_r    <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else if (perf_clr) begin
            ctrl_cnt_r    <= {CNT_W{1'b0}};
            mispred_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (enq_s && (ctrl_cnt_r != CNT_MAX_C)) begin
                ctrl_cnt_r <= ctrl_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            if (accept_s && mispred_s && (mispred_cnt_r != CNT_MAX_C)) begin
                mispred_cnt_r <= mispred_cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
        end
    end

    assign redirect_valid   = redirect_valid_r;
    assign redirect_pc      = redirect_pc_r;
    assign btb_upd_valid    = (count_r != EMPTY_C);
    assign btb_upd_pc       = q_pc_r[rd_ptr_r];
    assign btb_upd_target   = q_tgt_r[rd_ptr_r];
    assign btb_upd_taken    = q_tk_r[rd_ptr_r];
    assign perf_ctrl_cnt    = ctrl_cnt_r;
    assign perf_mispred_cnt = mispred_cnt_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected redirects and BTB
// entries, monitors pop and compare whenever the DUT presents them.
module tb_branch_resolve_unit;
    localparam int XLEN = 32;
    localparam int CNT_W = 4;
    localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111, ALU = 7'b0110011;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ex_valid = 1'b0;
    logic [XLEN-1:0] pc = '0, imm = '0, op1 = '0, pred_target = '0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic lt_flag = 1'b0, ltu_flag = 1'b0, zero_flag = 1'b0, pred_taken = 1'b0;
    logic btb_upd_ready = 1'b1, perf_clr = 1'b0;
    logic stall_req, redirect_valid, btb_upd_valid, btb_upd_taken;
    logic [XLEN-1:0] redirect_pc, btb_upd_pc, btb_upd_target;
    logic [CNT_W-1:0] perf_ctrl_cnt, perf_mispred_cnt;

    int checks = 0, errors = 0;
    int exp_ctrl = 0, exp_mis = 0;
    logic [XLEN-1:0] exp_rd[$];
    logic [2*XLEN:0] exp_btb[$];

    branch_resolve_unit #(.XLEN(XLEN), .BTBQ_DEPTH(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .pc(pc), .imm(imm), .op1(op1),
        .opcode(opcode), .func3(func3), .lt_flag(lt_flag), .ltu_flag(ltu_flag),
        .zero_flag(zero_flag), .pred_taken(pred_taken), .pred_target(pred_target),
        .stall_req(stall_req), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .btb_upd_valid(btb_upd_valid), .btb_upd_ready(btb_upd_ready),
        .btb_upd_pc(btb_upd_pc), .btb_upd_target(btb_upd_target),
        .btb_upd_taken(btb_upd_taken), .perf_clr(perf_clr),
        .perf_ctrl_cnt(perf_ctrl_cnt), .perf_mispred_cnt(perf_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Redirect monitor.
    always @(negedge clk) begin
        if (rst_n && redirect_valid) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_redirect", 64'(redirect_pc), 64'hDEAD);
            end else begin
                check("redirect_pc", 64'(redirect_pc), 64'(exp_rd.pop_front()));
            end
        end
    end

    // BTB update monitor.
    always @(negedge clk) begin
        if (rst_n && btb_upd_valid && btb_upd_ready) begin
            if (exp_btb.size() == 0) begin
                check("unexpected_btb_upd", 64'(btb_upd_pc), 64'hDEAD);
            end else begin
                logic [2*XLEN:0] e;
                e = exp_btb.pop_front();
                check("btb_upd_pc", 64'(btb_upd_pc), 64'(e[2*XLEN:XLEN+1]));
                check("btb_upd_target", 64'(btb_upd_target), 64'(e[XLEN:1]));
                check("btb_upd_taken", 64'(btb_upd_taken), 64'(e[0]));
            end
        end
    end

    // Drive one instruction for one cycle; flags = {lt, ltu, zero}.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] ipc,
                         input logic [31:0] iimm, input logic [31:0] iop1, input logic [2:0] flags,
                         input logic pt, input logic [31:0] ptgt, input logic acc,
                         input logic mis, input logic [31:0] rpc, input logic ctl,
                         input logic [31:0] tgt, input logic tk);
        opcode = opc; func3 = f3; pc = ipc; imm = iimm; op1 = iop1;
        {lt_flag, ltu_flag, zero_flag} = flags; pred_taken = pt; pred_target = ptgt;
        ex_valid = 1'b1;
        if (acc) begin
            if (mis) begin
                exp_rd.push_back(rpc);
                if (exp_mis < 15) exp_mis++;
            end
            if (ctl) begin
                exp_btb.push_back({ipc, tgt, tk});
                if (exp_ctrl < 15) exp_ctrl++;
            end
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_ctrl_cnt"}, 64'(perf_ctrl_cnt), 64'(exp_ctrl));
        check({tag, "_mispred_cnt"}, 64'(perf_mispred_cnt), 64'(exp_mis));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_btb_valid", 64'(btb_upd_valid), 64'd0);
        check_cnt("rst");
        #19 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        issue(BR,   3'b000, 32'h100, 32'h20, 32'h0, 3'b001, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h120, 1'b1, 32'h120, 1'b1);
        idle(1);
        check_cnt("beq");
        issue(JALR, 3'b000, 32'h300, 32'h4, 32'h2003, 3'b000, 1'b1, 32'h2004,
              1'b1, 1'b1, 32'h2006, 1'b1, 32'h2006, 1'b1);
        idle(1);
        issue(ALU,  3'b000, 32'h40, 32'h0, 32'h0, 3'b000, 1'b1, 32'h80,
              1'b1, 1'b1, 32'h44, 1'b0, 32'h0, 1'b0);
        idle(1);
        check_cnt("alu");
        issue(BR,   3'b001, 32'h500, 32'h10, 32'h0, 3'b000, 1'b1, 32'h510,
              1'b1, 1'b0, 32'h0, 1'b1, 32'h510, 1'b1);
        issue(BR,   3'b100, 32'h600, 32'hFFFFFFF8, 32'h0, 3'b000, 1'b1, 32'h5F8,
              1'b1, 1'b1, 32'h604, 1'b1, 32'h5F8, 1'b0);
        idle(1);
        issue(BR,   3'b111, 32'h700, 32'h40, 32'h0, 3'b000, 1'b1, 32'h744,
              1'b1, 1'b1, 32'h740, 1'b1, 32'h740, 1'b1);
        idle(1);
        issue(BR,   3'b010, 32'h800, 32'h4, 32'h0, 3'b111, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'h804, 1'b0);
        issue(JAL,  3'b000, 32'hFFFFFFF0, 32'h20, 32'h0, 3'b000, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        idle(2);
        check_cnt("vectors");

        // Instruction in the redirect cycle is squashed.
        issue(BR, 3'b000, 32'h900, 32'h10, 32'h0, 3'b001, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h910, 1'b1, 32'h910, 1'b1);
        issue(BR, 3'b000, 32'hA00, 32'h10, 32'h0, 3'b001, 1'b0, 32'h0,
              1'b0, 1'b1, 32'hA10, 1'b1, 32'hA10, 1'b1);
        idle(3);
        check_cnt("squash");

        // Queue full: fifth branch stalls until one entry drains.
        btb_upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(BR, 3'b000, 32'hB00 + 32'(i * 4), 32'h8, 32'h0, 3'b000, 1'b0, 32'h0,
                  1'b1, 1'b0, 32'h0, 1'b1, 32'hB08 + 32'(i * 4), 1'b0);
        end
        opcode = BR; func3 = 3'b000; pc = 32'hC00; imm = 32'h8;
        {lt_flag, ltu_flag, zero_flag} = 3'b000; pred_taken = 1'b0; ex_valid = 1'b1;
        @(negedge clk);
        check("stall_when_full", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        btb_upd_ready = 1'b1;
        @(negedge clk);
        check("stall_during_deq", 64'(stall_req), 64'd1);
        @(posedge clk); #1;
        btb_upd_ready = 1'b0;
        @(negedge clk);
        check("stall_released", 64'(stall_req), 64'd0);
        exp_btb.push_back({32'hC00, 32'hC08, 1'b0});
        exp_ctrl++;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        btb_upd_ready = 1'b1;
        idle(6);
        check_cnt("stall");

        // Saturation and clear priority.
        perf_clr = 1'b1;
        idle(1);
        perf_clr = 1'b0;
        exp_ctrl = 0; exp_mis = 0;
        for (int i = 0; i < 16; i++) begin
            issue(BR, 3'b000, 32'hD00 + 32'(i * 4), 32'h8, 32'h0, 3'b000, 1'b0, 32'h0,
                  1'b1, 1'b0, 32'h0, 1'b1, 32'hD08 + 32'(i * 4), 1'b0);
        end
        check("ctrl_cnt_saturated", 64'(perf_ctrl_cnt), 64'd15);
        perf_clr = 1'b1;
        issue(BR, 3'b000, 32'hE00, 32'h8, 32'h0, 3'b000, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'hE08, 1'b0);
        perf_clr = 1'b0;
        exp_ctrl = 0;
        check_cnt("clr");
        idle(2);

        // Reset mid-stream with a pending redirect and queued entries.
        btb_upd_ready = 1'b0;
        issue(BR, 3'b000, 32'hF00, 32'h8, 32'h0, 3'b000, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h0, 1'b1, 32'hF08, 1'b0);
        issue(BR, 3'b000, 32'hF04, 32'h8, 32'h0, 3'b001, 1'b0, 32'h0,
              1'b1, 1'b1, 32'hF0C, 1'b1, 32'hF0C, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("midrst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("midrst_btb_valid", 64'(btb_upd_valid), 64'd0);
        check("midrst_btb_fields", {btb_upd_pc, btb_upd_target} | 64'(btb_upd_taken), 64'd0);
        exp_rd.delete(); exp_btb.delete();
        exp_ctrl = 0; exp_mis = 0;
        check_cnt("midrst");
        btb_upd_ready = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(BR, 3'b101, 32'h1000, 32'h40, 32'h0, 3'b000, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h1040, 1'b1, 32'h1040, 1'b1);
        idle(3);
        check_cnt("postrst");

        check("redirects_outstanding", 64'(exp_rd.size()), 64'd0);
        check("btb_outstanding", 64'(exp_btb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
